// File: rtl/fp_div_round_pack_if.sv
// rtl/fp_div_round_pack_if.sv - upstream/downstream handshake bundle for the divider round/pack stage
interface fp_div_round_pack_if #(
    parameter int EW     = 8,
    parameter int FW     = 23,
    parameter int IEXP_W = EW + 2
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [IEXP_W-1:0] in_exp;
    logic [FW+3:0]     in_quo;
    logic              in_sticky;
    logic [1:0]        in_special;
    logic              in_invalid;
    logic              in_divzero;
    logic              out_valid;
    logic              out_ready;
    logic [EW+FW:0]    out_result;
    logic [4:0]        out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_quo, in_sticky, in_special,
               in_invalid, in_divzero, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_quo, in_sticky, in_special,
               in_invalid, in_divzero, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_div_round_pack.sv
// rtl/fp_div_round_pack.sv - normalize, RNE round and pack binary32 quotient in a 2-stage valid/ready pipe
module fp_div_round_pack #(
    parameter int EW     = 8,
    parameter int FW     = 23,
    parameter int IEXP_W = EW + 2
) (
    input logic                clk,
    input logic                rst_n,
    fp_div_round_pack_if.slave bus
);
    localparam int W  = FW + 4;
    // Two spare bits so exp-1 and exp+1 never wrap at the input range limits.
    localparam int XW = IEXP_W + 2;
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic signed [XW-1:0] r_s1_exp;
    logic [FW:0]          r_s1_m;
    logic                 r_s1_g;
    logic                 r_s1_s;
    logic [1:0]           r_s1_special;
    logic                 r_s1_invalid;
    logic                 r_s1_divzero;

    logic                 r_out_valid;
    logic [EW+FW:0]       r_out_result;
    logic [4:0]           r_out_flags;

    logic                 w_s2_load;
    logic                 w_s1_load;
    logic signed [XW-1:0] w_exp_ext;
    logic signed [XW-1:0] w_n_exp;
    logic [FW:0]          w_n_m;
    logic                 w_n_g;
    logic                 w_n_s;
    logic                 w_up;
    logic [FW+1:0]        w_mr;
    logic signed [XW-1:0] w_e2;
    logic                 w_nx;
    logic [EW+FW:0]       w_result;
    logic [4:0]           w_flags;

    assign w_s2_load     = ~r_out_valid | bus.out_ready;
    assign w_s1_load     = ~r_s1_valid | w_s2_load;
    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_flags  = r_out_flags;

    always_comb begin
        w_exp_ext = {{(XW-IEXP_W){bus.in_exp[IEXP_W-1]}}, bus.in_exp};
        w_n_m     = bus.in_quo[W-1:3];
        w_n_g     = bus.in_quo[2];
        w_n_s     = (|bus.in_quo[1:0]) | bus.in_sticky;
        w_n_exp   = w_exp_ext;
        if (!bus.in_quo[W-1]) begin
            w_n_m   = bus.in_quo[W-2:2];
            w_n_g   = bus.in_quo[1];
            w_n_s   = bus.in_quo[0] | bus.in_sticky;
            w_n_exp = w_exp_ext - XW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_m       <= '0;
            r_s1_g       <= 1'b0;
            r_s1_s       <= 1'b0;
            r_s1_special <= 2'b00;
            r_s1_invalid <= 1'b0;
            r_s1_divzero <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign    <= bus.in_sign;
                r_s1_exp     <= w_n_exp;
                r_s1_m       <= w_n_m;
                r_s1_g       <= w_n_g;
                r_s1_s       <= w_n_s;
                r_s1_special <= bus.in_special;
                r_s1_invalid <= bus.in_invalid;
                r_s1_divzero <= bus.in_divzero;
            end
        end
    end

    // A mantissa carry leaves w_mr = 10..0, so its low FW bits are already the correct fraction.
    always_comb begin
        w_up     = r_s1_g & (r_s1_s | r_s1_m[0]);
        w_mr     = {1'b0, r_s1_m} + {{(FW+1){1'b0}}, w_up};
        w_e2     = r_s1_exp + {{(XW-1){1'b0}}, w_mr[FW+1]};
        w_nx     = r_s1_g | r_s1_s;
        w_result = {r_s1_sign, w_e2[EW-1:0], w_mr[FW-1:0]};
        w_flags  = {r_s1_invalid, r_s1_divzero, 3'b000};
        case (r_s1_special)
            2'b01: w_result = {r_s1_sign, {(EW+FW){1'b0}}};
            2'b10: w_result = {r_s1_sign, {EW{1'b1}}, {FW{1'b0}}};
            2'b11: w_result = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            default: begin
                if (w_e2 >= EMAX) begin
                    w_result = {r_s1_sign, {EW{1'b1}}, {FW{1'b0}}};
                    w_flags  = {r_s1_invalid, r_s1_divzero, 3'b101};
                end else if (w_e2[XW-1] || (w_e2 == '0)) begin
                    w_result = {r_s1_sign, {(EW+FW){1'b0}}};
                    w_flags  = {r_s1_invalid, r_s1_divzero, 3'b011};
                end else begin
                    w_flags  = {r_s1_invalid, r_s1_divzero, 2'b00, w_nx};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= w_result;
                r_out_flags  <= w_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_div_round_pack.sv
// tb/tb_fp_div_round_pack.sv - scoreboard bench for fp_div_round_pack against an arithmetic rounding model
module tb_fp_div_round_pack;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 1;
    logic [36:0] pend;
    logic [36:0] sb[$];
    logic        held_valid = 1'b0;
    logic [36:0] held;

    fp_div_round_pack_if bus ();
    fp_div_round_pack dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Rounds by comparing the discarded remainder against one half of an ulp.
    function automatic logic [36:0] model(input logic sg, input logic signed [9:0] ex,
                                          input logic [26:0] q, input logic st,
                                          input logic [1:0] sp, input logic inv, input logic dz);
        int e; int sh; longint qq; longint kept; longint rem; longint half;
        logic up; logic nx; logic [31:0] res; logic [4:0] fl;
        fl = {inv, dz, 3'b000};
        res = 32'h0;
        case (sp)
            2'd1: res = {sg, 31'h0};
            2'd2: res = {sg, 8'hFF, 23'h0};
            2'd3: res = 32'h7FC00000;
            default: begin
                qq = longint'(q);
                sh = (qq >= 64'd67108864) ? 3 : 2;
                e = ex;
                if (sh == 2) e = e - 1;
                kept = qq >> sh;
                rem  = qq % (64'd1 << sh);
                half = 64'd1 << (sh - 1);
                up = (rem > half) || (rem == half && (st || (kept % 2 == 1)));
                nx = (rem != 0) || st;
                if (up) kept = kept + 1;
                if (kept == 64'd16777216) begin
                    kept = kept / 2;
                    e = e + 1;
                end
                if (e >= 255) begin
                    res = {sg, 8'hFF, 23'h0};
                    fl = fl | 5'b00101;
                end else if (e <= 0) begin
                    res = {sg, 31'h0};
                    fl = fl | 5'b00011;
                end else begin
                    res = {sg, 8'(e), 23'(kept % 64'd8388608)};
                    if (nx) fl = fl | 5'b00001;
                end
            end
        endcase
        return {res, fl};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b0;
                1: bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) sb.push_back(pend);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=%h required=none", {bus.out_result, bus.out_flags});
                end else begin
                    chk("result_flags", 64'({bus.out_result, bus.out_flags}), 64'(sb.pop_front()));
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (held_valid) chk("stall_stable", 64'({bus.out_result, bus.out_flags}), 64'(held));
                held = {bus.out_result, bus.out_flags};
                held_valid = 1'b1;
            end else begin
                held_valid = 1'b0;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic load_in(input logic sg, input logic [9:0] ex, input logic [26:0] q,
                           input logic st, input logic [1:0] sp, input logic inv,
                           input logic dz, input logic use_exp, input logic [36:0] exp);
        bus.in_sign = sg;
        bus.in_exp = ex;
        bus.in_quo = q;
        bus.in_sticky = st;
        bus.in_special = sp;
        bus.in_invalid = inv;
        bus.in_divzero = dz;
        pend = use_exp ? exp : model(sg, ex, q, st, sp, inv, dz);
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic sg, input logic [9:0] ex, input logic [26:0] q,
                        input logic st, input logic [1:0] sp, input logic inv,
                        input logic dz, input logic use_exp, input logic [36:0] exp);
        load_in(sg, ex, q, st, sp, inv, dz, use_exp, exp);
        wait_accept();
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exp = '0;
        bus.in_quo = '0;
        bus.in_sticky = 1'b0;
        bus.in_special = 2'b00;
        bus.in_invalid = 1'b0;
        bus.in_divzero = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_result", 64'(bus.out_result), 64'd0);
        chk("reset_out_flags", 64'(bus.out_flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

        send(1'b0, 10'd128, 27'h4000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h40000000, 5'b00000});
        send(1'b0, 10'd126, 27'h2AAAAAA, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, {32'h3EAAAAAB, 5'b00001});
        send(1'b1, 10'd127, 27'h7FFFFFF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'hC0000000, 5'b00001});
        send(1'b0, 10'd255, 27'h4000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h7F800000, 5'b00101});
        send(1'b0, 10'd0,   27'h4000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h00000000, 5'b00011});
        send(1'b1, 10'd5,   27'h4000000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, {32'h7FC00000, 5'b10000});
        send(1'b1, 10'd254, 27'h7FFFFFF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'hFF800000, 5'b00101});
        send(1'b0, 10'd1,   27'h2000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h00000000, 5'b00011});
        send(1'b1, 10'd2,   27'h2000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h80800000, 5'b00000});
        send(1'b0, 10'h200, 27'h2000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h00000000, 5'b00011});
        send(1'b0, 10'd254, 27'h4000004, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h7F000000, 5'b00001});
        send(1'b1, 10'd100, 27'h0,       1'b0, 2'b01, 1'b0, 1'b1, 1'b1, {32'h80000000, 5'b01000});
        send(1'b1, 10'd100, 27'h0,       1'b0, 2'b10, 1'b0, 1'b1, 1'b1, {32'hFF800000, 5'b01000});
        wait_empty();

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            int ex;
            ex = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? -512 : 511)
                                             : (int'($urandom_range(0, 265)) - 5);
            send(1'($urandom), 10'(ex), 27'($urandom_range(27'h2000000, 27'h7FFFFFF)), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 1'b0, '0);
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        wait_empty();

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 10'd130, 27'h5555555, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        send(1'b1, 10'd90,  27'h3333333, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        load_in(1'b0, 10'd140, 27'h7FFFFFC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        repeat (4) @(negedge clk);
        rdy_mode = 1;
        wait_accept();
        wait_empty();

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 10'd120, 27'h4567890, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        send(1'b0, 10'd121, 27'h3456789, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (10) @(negedge clk);
        chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
        send(1'b0, 10'd128, 27'h4000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, {32'h40000000, 5'b00000});
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
